mips32_pipeline: RTL and testbench
==================================

Name: mips32_pipeline

Overview:
- 32-bit, 5-stage in-order pipelined MIPS-like core: IF, ID, EX, MEM, WB.
- Single unified word-addressed memory holds both instructions and data.
- Standalone execution block. The bench preloads memory and registers hierarchically, releases reset, runs until halted, then inspects registers and memory.

Parameters:
MEM_DEPTH  1024  number of 32-bit words in the unified memory (Memory[0:MEM_DEPTH-1])
PC_W       32    program counter width; counts words, not bytes

Ports:
clk     input   1   single system clock, rising edge
rst_n   input   1   asynchronous active-low reset
halted  output  1   high once an HLT has retired; sticky until reset
pc      output  32  current fetch PC, for debug

Behaviour:
- Interface:
  - One clock; reset is asynchronous and active-low.
  - Internal arrays are named Reg[0:31] and Memory[0:MEM_DEPTH-1] so the bench can preload them hierarchically.
- Reset:
  - pc=0, halted=0, branch-taken flag=0, all pipeline registers hold NOP (no writeback, no memory write).
  - Reg and Memory contents are NOT altered by reset.
- Encoding: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0] sign-extended.
- R-type ops, write Reg[rd]:
  - ADD 000000
  - SUB 000001
  - AND 000010
  - OR 000011
  - SLT 000100 (signed, result 1/0)
  - MUL 000101 (low 32 bits)
- Immediate ops, write Reg[rt]:
  - ADDI 001010
  - SUBI 001011
  - SLTI 001100
- Memory ops:
  - LW 001000: Reg[rt]=Memory[Reg[rs]+imm]
  - SW 001001: Memory[Reg[rs]+imm]=Reg[rt]
- Branches:
  - BNEQZ 001101: taken if Reg[rs]!=0
  - BEQZ 001110: taken if Reg[rs]==0
  - Target = (address of branch + 1) + imm.
- HLT 111111.
- Any other opcode is a NOP.
- Arithmetic: 32-bit two's complement; overflow wraps; no exceptions. Memory addresses use the low log2(MEM_DEPTH) bits.
- Register 0 always reads 0; writes to it are discarded.
- Timing: one instruction issued per cycle. Latency from fetch to writeback is 5 cycles.
- Register file is write-first: an ID-stage read of a register written in WB that same cycle returns the new value.
- Forwarding:
  - EX operands forward from EX/MEM (ALU result) and MEM/WB (ALU or load result), youngest first.
  - No load-use interlock: the instruction immediately after LW must not use the LW's rt; software inserts one independent instruction.
- Branch:
  - Resolved in EX.
  - If taken: pc<=target and the two younger instructions in IF/ID and ID/EX are squashed to NOP, giving a 2-cycle penalty.
  - If not taken: no penalty.
- HLT:
  - When HLT is decoded in ID, fetch stops and pc freezes; the instruction in IF is squashed.
  - Older instructions complete normally.
  - halted rises the cycle HLT reaches WB. After that, no register or memory writes occur until reset.
  - An HLT squashed by a taken branch has no effect.
- Reset asserted mid-program aborts all in-flight instructions immediately with no partial writes. Register and memory contents written before reset remain.

Test Plan:
1. Add-three:
   - Stimulus: Reg[k]=k; Memory[0..6]=2801000a, 28020014, 28030019, 00222000, 0c373800, 00832800, fc000000.
   - Required: R0=0, R1=10, R2=20, R3=25, R4=30, R5=55, R7=R1|R23=31; halted=1 within 15 cycles.
2. Back-to-back dependency without a dummy, checking forwarding:
   - Stimulus: ADDI R1,R0,5; ADD R2,R1,R1; ADD R3,R2,R1; HLT.
   - Required: R2=10, R3=15.
3. Load/store:
   - Stimulus: Memory[120]=85; LW R2,0(R1) with R1=120; NOP; ADDI R2,R2,45; SW R2,1(R1); HLT.
   - Required: Memory[121]=130.
4. Loop (factorial):
   - Stimulus: R10=200, Memory[200]=7; loop using MUL, SUBI and BNEQZ.
   - Required: Memory[198]=5040; instructions after the branch in the shadow are never retired.
5. Halt: instructions placed after HLT (e.g. ADDI R9,R0,1) never write (R9 unchanged); pc stays frozen.
6. Reset:
   - Stimulus: assert rst_n=0 mid-run.
   - Required: pc=0 and halted=0 immediately; after release, the program reruns from address 0.

Source files
------------

// File: rtl/mips32_pipeline_if.sv
// Observation bundle for the MIPS32 pipeline: halt status and fetch PC.
// The core drives it through the master modport; observers use the slave modport.
interface mips32_pipeline_if #(
   parameter int PC_W = 32
);
   logic            halted;
   logic [PC_W-1:0] pc;

   modport master (output halted, output pc);
   modport slave  (input halted, input pc);
endinterface

// File: rtl/mips32_pipeline.sv
// 5-stage in-order MIPS-like core (IF, ID, EX, MEM, WB) with a unified word-addressed memory,
// EX-stage operand forwarding, branches resolved in EX and a sticky HLT.
module mips32_pipeline #(
   parameter int MEM_DEPTH = 1024,
   parameter int PC_W      = 32,
   parameter int DATA_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   mips32_pipeline_if.master bus
);
   localparam int AW = $clog2(MEM_DEPTH);

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_AND   = 6'b000010;
   localparam logic [5:0] OP_OR    = 6'b000011;
   localparam logic [5:0] OP_SLT   = 6'b000100;
   localparam logic [5:0] OP_MUL   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b001000;
   localparam logic [5:0] OP_SW    = 6'b001001;
   localparam logic [5:0] OP_ADDI  = 6'b001010;
   localparam logic [5:0] OP_SUBI  = 6'b001011;
   localparam logic [5:0] OP_SLTI  = 6'b001100;
   localparam logic [5:0] OP_BNEQZ = 6'b001101;
   localparam logic [5:0] OP_BEQZ  = 6'b001110;
   localparam logic [5:0] OP_HLT   = 6'b111111;

   logic [DATA_W-1:0] Reg    [0:31];
   logic [DATA_W-1:0] Memory [0:MEM_DEPTH-1];

   logic [PC_W-1:0] pc;
   logic            halted;
   logic            stopped;

   logic                     vld_p1;
   logic [31:0]              instr_p1;
   logic [PC_W-1:0]          npc_p1;

   logic                     vld_p2, wr_p2;
   logic [5:0]               op_p2;
   logic [4:0]               rs_p2, rt_p2, dst_p2;
   logic signed [DATA_W-1:0] a_p2, b_p2, imm_p2;
   logic [PC_W-1:0]          npc_p2;

   logic                     vld_p3, wr_p3, ld_p3, st_p3, hlt_p3;
   logic [4:0]               dst_p3;
   logic signed [DATA_W-1:0] alu_p3, sd_p3;

   logic                     vld_p4, wr_p4, hlt_p4;
   logic [4:0]               dst_p4;
   logic signed [DATA_W-1:0] wd_p4;

   function automatic logic signed [DATA_W-1:0] alu(input logic [5:0] op,
                                                     input logic signed [DATA_W-1:0] x,
                                                     input logic signed [DATA_W-1:0] y);
      alu = '0;
      case (op)
         OP_SUB, OP_SUBI: alu = x - y;
         OP_AND:          alu = x & y;
         OP_OR:           alu = x | y;
         OP_SLT, OP_SLTI: alu[0] = (x < y);
         OP_MUL:          alu = x * y;
         default:         alu = x + y;
      endcase
   endfunction

   // ID: decode, write-first register read
   logic [5:0]               op_id;
   logic [4:0]               rs_id, rt_id, rd_id, dst_id;
   logic                     wr_id, hlt_id, wb_en, taken;
   logic signed [DATA_W-1:0] imm_id, ra_id, rb_id;

   assign op_id  = instr_p1[31:26];
   assign rs_id  = instr_p1[25:21];
   assign rt_id  = instr_p1[20:16];
   assign rd_id  = instr_p1[15:11];
   assign imm_id = {{(DATA_W-16){instr_p1[15]}}, instr_p1[15:0]};
   assign wb_en  = vld_p4 && wr_p4 && !halted;
   assign hlt_id = vld_p1 && (op_id == OP_HLT) && !taken;

   always_comb begin
      wr_id  = 1'b0;
      dst_id = rt_id;
      case (op_id)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
            wr_id  = 1'b1;
            dst_id = rd_id;
         end
         OP_ADDI, OP_SUBI, OP_SLTI, OP_LW: wr_id = 1'b1;
         default: wr_id = 1'b0;
      endcase
      if (dst_id == 5'd0) wr_id = 1'b0;

      ra_id = Reg[rs_id];
      if (rs_id == 5'd0) ra_id = '0;
      else if (wb_en && dst_p4 == rs_id) ra_id = wd_p4;
      rb_id = Reg[rt_id];
      if (rt_id == 5'd0) rb_id = '0;
      else if (wb_en && dst_p4 == rt_id) rb_id = wd_p4;
   end

   // EX: forwarding (EX/MEM before MEM/WB), ALU, branch resolution
   logic signed [DATA_W-1:0] fa, fb, opb, res_ex;
   logic                     imm_op;
   logic [PC_W-1:0]          target;

   always_comb begin
      fa = a_p2;
      if (vld_p3 && wr_p3 && !ld_p3 && dst_p3 == rs_p2) fa = alu_p3;
      else if (wb_en && dst_p4 == rs_p2) fa = wd_p4;
      fb = b_p2;
      if (vld_p3 && wr_p3 && !ld_p3 && dst_p3 == rt_p2) fb = alu_p3;
      else if (wb_en && dst_p4 == rt_p2) fb = wd_p4;
   end

   assign imm_op = (op_p2 == OP_ADDI) || (op_p2 == OP_SUBI) || (op_p2 == OP_SLTI) ||
                   (op_p2 == OP_LW)   || (op_p2 == OP_SW);
   assign opb    = imm_op ? imm_p2 : fb;
   assign res_ex = alu(op_p2, fa, opb);
   assign taken  = vld_p2 && (((op_p2 == OP_BNEQZ) && (fa != '0)) ||
                              ((op_p2 == OP_BEQZ)  && (fa == '0)));
   assign target = npc_p2 + PC_W'(unsigned'(imm_p2));

   // MEM: unified memory access
   logic [DATA_W-1:0] rd_mem;
   logic              st_en;

   assign rd_mem = Memory[alu_p3[AW-1:0]];
   assign st_en  = vld_p3 && st_p3 && !halted;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc      <= '0;
         halted  <= 1'b0;
         stopped <= 1'b0;
         vld_p1  <= 1'b0;
         vld_p2  <= 1'b0;
         vld_p3  <= 1'b0;
         vld_p4  <= 1'b0;
      end else begin
         if (taken) begin
            pc     <= target;
            vld_p1 <= 1'b0;
         end else if (hlt_id || stopped) begin
            vld_p1 <= 1'b0;
            if (hlt_id) stopped <= 1'b1;
         end else begin
            pc     <= pc + 1'b1;
            vld_p1 <= 1'b1;
         end
         vld_p2 <= vld_p1 && !taken;
         vld_p3 <= vld_p2;
         vld_p4 <= vld_p3;
         if (vld_p4 && hlt_p4) halted <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      instr_p1 <= Memory[pc[AW-1:0]];
      npc_p1   <= pc + 1'b1;

      op_p2  <= op_id;
      rs_p2  <= rs_id;
      rt_p2  <= rt_id;
      dst_p2 <= dst_id;
      wr_p2  <= wr_id;
      a_p2   <= ra_id;
      b_p2   <= rb_id;
      imm_p2 <= imm_id;
      npc_p2 <= npc_p1;

      wr_p3  <= wr_p2;
      ld_p3  <= (op_p2 == OP_LW);
      st_p3  <= (op_p2 == OP_SW);
      hlt_p3 <= (op_p2 == OP_HLT);
      dst_p3 <= dst_p2;
      alu_p3 <= res_ex;
      sd_p3  <= fb;

      wr_p4  <= wr_p3;
      hlt_p4 <= hlt_p3;
      dst_p4 <= dst_p3;
      wd_p4  <= ld_p3 ? rd_mem : alu_p3;

      if (st_en) Memory[alu_p3[AW-1:0]] <= sd_p3;
      if (wb_en) Reg[dst_p4] <= wd_p4;
   end

   assign bus.pc     = pc;
   assign bus.halted = halted;
endmodule

// File: tb/tb_mips32_pipeline.sv
// Directed bench for mips32_pipeline: preloads programs hierarchically, runs to HLT,
// then checks registers, memory, pc and halted against hand-computed values.
module tb_mips32_pipeline;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   mips32_pipeline_if #(.PC_W(32)) bus ();

   mips32_pipeline #(.MEM_DEPTH(1024), .PC_W(32), .DATA_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
      return {op, rs, rt, rd, 11'b0};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Enter reset on a falling edge, clear memory and set Reg[k]=k.
   task automatic enter_reset();
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < 1024; i++) dut.Memory[i] = 32'h0;
      for (int r = 0; r < 32; r++) dut.Reg[r] = r;
   endtask

   task automatic leave_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_to_halt(input string tag, input int budget);
      int cyc = 0;
      while (bus.halted !== 1'b1 && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      chk(tag, {31'b0, bus.halted}, 32'd1);
   endtask

   localparam logic [31:0] HLT = 32'hfc000000;
   localparam logic [31:0] NOP = 32'h7c000000;

   initial begin
      // Reset state
      @(negedge clk);
      chk("reset_pc", bus.pc, 32'd0);
      chk("reset_halted", {31'b0, bus.halted}, 32'd0);

      // 1. Add-three
      enter_reset();
      dut.Memory[0] = 32'h2801000a;
      dut.Memory[1] = 32'h28020014;
      dut.Memory[2] = 32'h28030019;
      dut.Memory[3] = 32'h00222000;
      dut.Memory[4] = 32'h0c373800;
      dut.Memory[5] = 32'h00832800;
      dut.Memory[6] = HLT;
      leave_reset();
      run_to_halt("t1_halt15", 15);
      chk("t1_r0", dut.Reg[0], 32'd0);
      chk("t1_r1", dut.Reg[1], 32'd10);
      chk("t1_r2", dut.Reg[2], 32'd20);
      chk("t1_r3", dut.Reg[3], 32'd25);
      chk("t1_r4", dut.Reg[4], 32'd30);
      chk("t1_r5", dut.Reg[5], 32'd55);
      chk("t1_r7", dut.Reg[7], 32'd31);
      chk("t1_r6", dut.Reg[6], 32'd6);
      chk("t1_pc", bus.pc, 32'd7);

      // 2. Back-to-back forwarding
      enter_reset();
      dut.Memory[0] = enc_i(6'b001010, 5'd0, 5'd1, 16'd5);
      dut.Memory[1] = enc_r(6'b000000, 5'd1, 5'd1, 5'd2);
      dut.Memory[2] = enc_r(6'b000000, 5'd2, 5'd1, 5'd3);
      dut.Memory[3] = HLT;
      leave_reset();
      run_to_halt("t2_halt", 40);
      chk("t2_r1", dut.Reg[1], 32'd5);
      chk("t2_r2", dut.Reg[2], 32'd10);
      chk("t2_r3", dut.Reg[3], 32'd15);

      // 3. Load / store with load-data and store-data forwarding
      enter_reset();
      dut.Reg[1]      = 32'd120;
      dut.Memory[120] = 32'd85;
      dut.Memory[0] = enc_i(6'b001000, 5'd1, 5'd2, 16'd0);
      dut.Memory[1] = NOP;
      dut.Memory[2] = enc_i(6'b001010, 5'd2, 5'd2, 16'd45);
      dut.Memory[3] = enc_i(6'b001001, 5'd1, 5'd2, 16'd1);
      dut.Memory[4] = HLT;
      leave_reset();
      run_to_halt("t3_halt", 40);
      chk("t3_mem121", dut.Memory[121], 32'd130);
      chk("t3_r2", dut.Reg[2], 32'd130);
      chk("t3_mem120", dut.Memory[120], 32'd85);

      // 4. Factorial loop; R11/R12 sit in the branch shadow
      enter_reset();
      dut.Reg[10]     = 32'd200;
      dut.Memory[200] = 32'd7;
      dut.Memory[0] = enc_i(6'b001010, 5'd0, 5'd2, 16'd1);
      dut.Memory[1] = enc_i(6'b001000, 5'd10, 5'd3, 16'd0);
      dut.Memory[2] = NOP;
      dut.Memory[3] = enc_r(6'b000101, 5'd2, 5'd3, 5'd2);
      dut.Memory[4] = enc_i(6'b001011, 5'd3, 5'd3, 16'd1);
      dut.Memory[5] = enc_i(6'b001101, 5'd3, 5'd0, 16'hfffd);
      dut.Memory[6] = enc_i(6'b001010, 5'd11, 5'd11, 16'd1);
      dut.Memory[7] = enc_i(6'b001010, 5'd12, 5'd12, 16'd1);
      dut.Memory[8] = enc_i(6'b001001, 5'd10, 5'd2, 16'hfffe);
      dut.Memory[9] = HLT;
      leave_reset();
      run_to_halt("t4_halt", 200);
      chk("t4_mem198", dut.Memory[198], 32'd5040);
      chk("t4_r2", dut.Reg[2], 32'd5040);
      chk("t4_r3", dut.Reg[3], 32'd0);
      chk("t4_shadow_r11", dut.Reg[11], 32'd12);
      chk("t4_shadow_r12", dut.Reg[12], 32'd13);
      chk("t4_pc", bus.pc, 32'd10);

      // 5. Nothing after HLT retires; pc frozen
      enter_reset();
      dut.Memory[0] = enc_i(6'b001010, 5'd0, 5'd8, 16'd3);
      dut.Memory[1] = HLT;
      dut.Memory[2] = enc_i(6'b001010, 5'd0, 5'd9, 16'd1);
      dut.Memory[3] = enc_i(6'b001010, 5'd0, 5'd9, 16'd2);
      leave_reset();
      run_to_halt("t5_halt", 40);
      chk("t5_r8", dut.Reg[8], 32'd3);
      chk("t5_r9", dut.Reg[9], 32'd9);
      chk("t5_pc", bus.pc, 32'd2);
      repeat (10) @(negedge clk);
      chk("t5_pc_frozen", bus.pc, 32'd2);
      chk("t5_halted_sticky", {31'b0, bus.halted}, 32'd1);
      chk("t5_r9_late", dut.Reg[9], 32'd9);

      // 6. Asynchronous reset while halted and mid-run
      enter_reset();
      dut.Memory[0] = enc_i(6'b001010, 5'd1, 5'd1, 16'd1);
      dut.Memory[1] = HLT;
      leave_reset();
      run_to_halt("t6_halt1", 40);
      chk("t6_r1_first", dut.Reg[1], 32'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_pc", bus.pc, 32'd0);
      chk("t6_async_halted", {31'b0, bus.halted}, 32'd0);
      chk("t6_r1_kept", dut.Reg[1], 32'd2);
      chk("t6_mem_kept", dut.Memory[0], 32'h28210001);
      leave_reset();
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_midrun_pc", bus.pc, 32'd0);
      repeat (3) @(negedge clk);
      chk("t6_no_partial", dut.Reg[1], 32'd2);
      leave_reset();
      run_to_halt("t6_halt2", 40);
      chk("t6_rerun_r1", dut.Reg[1], 32'd3);
      chk("t6_rerun_pc", bus.pc, 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
